// File: rtl/stage_buffer_pkg.sv
// Shared definitions for the elastic stage buffer: parameter defaults and
// the per-cycle storage operation encoding used by the control logic.
package stage_buffer_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_TAGW  = 4;

  // Storage-side operation for one cycle; a bypassed word is neither.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } buf_op_e;

  function automatic buf_op_e decode_op(input logic wr, input logic rd);
    return buf_op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/stage_buffer_mem.sv
// DEPTH-entry register array holding {tag, payload} words; one write port,
// asynchronous (show-ahead) read port.
module stage_buffer_mem #(
  parameter int DW    = 36,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrEn,
  input  logic [AW-1:0] wrPtr,
  input  logic [DW-1:0] wrData,
  input  logic [AW-1:0] rdPtr,
  output logic [DW-1:0] rdData
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are zeroed only by reset; a flush leaves stale words in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrPtr] <= wrData;
    end
  end

  assign rdData = mem[rdPtr];

endmodule

// File: rtl/stage_buffer.sv
// Elastic buffer between two pipeline stages: DEPTH-entry queue with optional
// zero-latency bypass, synchronous flush and a per-word sequence tag.
module stage_buffer
  import stage_buffer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAGW   = DEF_TAGW,
  parameter int BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     readyIn,
  input  logic [WIDTH-1:0]         dataIn,
  output logic                     triggerOut,
  output logic                     readyOut,
  output logic [WIDTH-1:0]         dataOut,
  output logic [TAGW-1:0]          seqOut,
  input  logic                     triggerIn,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [TAGW-1:0]       seq_cnt;
  logic [WIDTH+TAGW-1:0] rd_word;
  logic                  bypass_active;
  logic                  push;
  logic                  pop;
  logic                  pass_through;
  logic                  wr_en;
  logic                  rd_en;
  buf_op_e               op;

  assign count = count_q;
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // Acceptance never looks at triggerIn, so a full buffer refuses even when popping.
  assign bypass_active = BYPASS_EN && empty;
  assign triggerOut    = reset && !full && !flush;
  assign readyOut      = reset && !flush && (!empty || (bypass_active && readyIn));

  assign push         = readyIn && triggerOut;
  assign pop          = readyOut && triggerIn;
  assign pass_through = bypass_active && push && pop;
  assign wr_en        = push && !pass_through;
  assign rd_en        = pop && !pass_through;
  assign op           = decode_op(wr_en, rd_en);

  always_comb begin
    dataOut = rd_word[WIDTH-1:0];
    seqOut  = rd_word[WIDTH +: TAGW];
    if (!reset) begin
      dataOut = '0;
      seqOut  = '0;
    end else if (bypass_active) begin
      dataOut = dataIn;
      seqOut  = seq_cnt;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count_q <= count_q - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The tag survives flushes so ordering checks can span a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  stage_buffer_mem #(
    .DW    (WIDTH + TAGW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (wr_en),
    .wrPtr  (wr_ptr),
    .wrData ({seq_cnt, dataIn}),
    .rdPtr  (rd_ptr),
    .rdData (rd_word)
  );

endmodule

// File: tb/tb_stage_buffer.sv
// Bench for stage_buffer: a queue model checked every cycle on two instances
// (BYPASS=0 and BYPASS=1) plus directed vectors with literal expectations.
module tb_stage_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  typedef logic [TAGW+WIDTH-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] ready_in, trigger_in, flush;
  logic [1:0] trigger_out, ready_out, full, empty;
  logic [1:0][WIDTH-1:0] data_in, data_out;
  logic [1:0][TAGW-1:0]  seq_out;
  logic [1:0][2:0]       count;

  int vectors = 0;
  int miscompares = 0;

  word_t mq [2][$];
  int    seq_m [2];

  always #5 clk = ~clk;

  stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .readyIn(ready_in[0]), .dataIn(data_in[0]),
    .triggerOut(trigger_out[0]), .readyOut(ready_out[0]), .dataOut(data_out[0]),
    .seqOut(seq_out[0]), .triggerIn(trigger_in[0]), .flush(flush[0]),
    .count(count[0]), .full(full[0]), .empty(empty[0])
  );

  stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .readyIn(ready_in[1]), .dataIn(data_in[1]),
    .triggerOut(trigger_out[1]), .readyOut(ready_out[1]), .dataOut(data_out[1]),
    .seqOut(seq_out[1]), .triggerIn(trigger_in[1]), .flush(flush[1]),
    .count(count[1]), .full(full[1]), .empty(empty[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic rdy, input logic [WIDTH-1:0] d,
                               input logic trg, input logic fl);
    ready_in[k]   = rdy;
    data_in[k]    = d;
    trigger_in[k] = trg;
    flush[k]      = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue model: outputs follow from occupancy and the head word; the state
  // update it then applies is the one the coming rising edge must perform.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int    n;
      logic  exp_trig, exp_ready, do_push, do_pop;
      word_t head, incoming;
      if (!reset) begin
        mq[k].delete();
        seq_m[k] = 0;
        checkOutput($sformatf("m%0d.rst.count", k), 64'(count[k]), 64'd0);
        checkOutput($sformatf("m%0d.rst.empty", k), 64'(empty[k]), 64'd1);
        checkOutput($sformatf("m%0d.rst.full", k), 64'(full[k]), 64'd0);
        checkOutput($sformatf("m%0d.rst.triggerOut", k), 64'(trigger_out[k]), 64'd0);
        checkOutput($sformatf("m%0d.rst.readyOut", k), 64'(ready_out[k]), 64'd0);
        checkOutput($sformatf("m%0d.rst.dataOut", k), 64'(data_out[k]), 64'd0);
        checkOutput($sformatf("m%0d.rst.seqOut", k), 64'(seq_out[k]), 64'd0);
      end else begin
        n        = mq[k].size();
        incoming = {seq_m[k][TAGW-1:0], data_in[k]};
        head     = (n > 0) ? mq[k][0] : incoming;
        exp_trig  = (n < DEPTH) && !flush[k];
        exp_ready = !flush[k] && ((n > 0) || ((k == 1) && ready_in[k]));
        checkOutput($sformatf("m%0d.count", k), 64'(count[k]), 64'(n));
        checkOutput($sformatf("m%0d.full", k), 64'(full[k]), 64'(n == DEPTH));
        checkOutput($sformatf("m%0d.empty", k), 64'(empty[k]), 64'(n == 0));
        checkOutput($sformatf("m%0d.triggerOut", k), 64'(trigger_out[k]), 64'(exp_trig));
        checkOutput($sformatf("m%0d.readyOut", k), 64'(ready_out[k]), 64'(exp_ready));
        if (exp_ready) begin
          checkOutput($sformatf("m%0d.dataOut", k), 64'(data_out[k]), 64'(head[WIDTH-1:0]));
          checkOutput($sformatf("m%0d.seqOut", k), 64'(seq_out[k]), 64'(head[WIDTH +: TAGW]));
        end
        if (flush[k]) begin
          mq[k].delete();
        end else begin
          do_push = ready_in[k] && exp_trig;
          do_pop  = exp_ready && trigger_in[k];
          if (do_pop && n > 0) void'(mq[k].pop_front());
          if (do_push && !(do_pop && n == 0)) mq[k].push_back(incoming);
          if (do_push) seq_m[k] = seq_m[k] + 1;
        end
      end
    end
  end

  initial begin
    reset      = 1'b0;
    ready_in   = '0;
    trigger_in = '0;
    flush      = '0;
    data_in    = '0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset.count", 64'(count[0]), 64'd0);
    checkOutput("reset.empty", 64'(empty[0]), 64'd1);
    checkOutput("reset.readyOut", 64'(ready_out[0]), 64'd0);
    checkOutput("reset.triggerOut", 64'(trigger_out[0]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 checkOutput("release.triggerOut", 64'(trigger_out[0]), 64'd1);

    // Fill A0..A3, then drain in order with tags 0..3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 32'hA0 + i, 1'b0, 1'b0);
      step();
    end
    applyStimulus(0, 1'b1, 32'hA4, 1'b0, 1'b0);
    checkOutput("fill.full", 64'(full[0]), 64'd1);
    checkOutput("fill.triggerOut", 64'(trigger_out[0]), 64'd0);
    checkOutput("fill.count", 64'(count[0]), 64'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("drain.readyOut", 64'(ready_out[0]), 64'd1);
      checkOutput("drain.dataOut", 64'(data_out[0]), 64'(32'hA0 + i));
      checkOutput("drain.seqOut", 64'(seq_out[0]), 64'(i));
      step();
    end
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("drain.empty", 64'(empty[0]), 64'd1);
    checkOutput("drain.readyOut_end", 64'(ready_out[0]), 64'd0);

    // Streaming at count=2: tags 4..23 wrap through 15->0.
    applyStimulus(0, 1'b1, 32'h100, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b1, 32'h101, 1'b0, 1'b0); step();
    for (int j = 0; j < 20; j++) begin
      applyStimulus(0, 1'b1, 32'h200 + j, 1'b1, 1'b0);
      checkOutput("stream.count", 64'(count[0]), 64'd2);
      checkOutput("stream.dataOut", 64'(data_out[0]),
                  64'((j < 2) ? (32'h100 + j) : (32'h200 + j - 2)));
      checkOutput("stream.seqOut", 64'(seq_out[0]), 64'((4 + j) % 16));
      step();
    end

    // Full with a same-cycle pop: push refused, accepted the cycle after.
    applyStimulus(0, 1'b1, 32'h300, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b1, 32'h301, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b1, 32'h400, 1'b1, 1'b0);
    checkOutput("fullpop.count", 64'(count[0]), 64'd4);
    checkOutput("fullpop.triggerOut", 64'(trigger_out[0]), 64'd0);
    checkOutput("fullpop.dataOut", 64'(data_out[0]), 64'h212);
    checkOutput("fullpop.seqOut", 64'(seq_out[0]), 64'd8);
    step();
    checkOutput("fullpop.count_after", 64'(count[0]), 64'd3);
    applyStimulus(0, 1'b1, 32'h400, 1'b0, 1'b0);
    checkOutput("fullpop.triggerOut_after", 64'(trigger_out[0]), 64'd1);
    step();
    checkOutput("fullpop.count_refill", 64'(count[0]), 64'd4);

    // Flush at count=3; the tag counter keeps running afterwards.
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0); step();
    applyStimulus(0, 1'b1, 32'h500, 1'b0, 1'b1);
    checkOutput("flush.triggerOut", 64'(trigger_out[0]), 64'd0);
    checkOutput("flush.readyOut", 64'(ready_out[0]), 64'd0);
    step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush.count", 64'(count[0]), 64'd0);
    checkOutput("flush.readyOut_after", 64'(ready_out[0]), 64'd0);
    applyStimulus(0, 1'b1, 32'h600, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush.next_dataOut", 64'(data_out[0]), 64'h600);
    checkOutput("flush.next_seqOut", 64'(seq_out[0]), 64'd13);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0); step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Bypass instance: pass-through when empty, FIFO once a word is stored.
    applyStimulus(1, 1'b1, 32'h55, 1'b1, 1'b0);
    checkOutput("bypass.readyOut", 64'(ready_out[1]), 64'd1);
    checkOutput("bypass.dataOut", 64'(data_out[1]), 64'h55);
    checkOutput("bypass.seqOut", 64'(seq_out[1]), 64'd0);
    step();
    checkOutput("bypass.count", 64'(count[1]), 64'd0);
    applyStimulus(1, 1'b1, 32'h66, 1'b0, 1'b0);
    checkOutput("bypass.hold_dataOut", 64'(data_out[1]), 64'h66);
    step();
    checkOutput("bypass.stored_count", 64'(count[1]), 64'd1);
    applyStimulus(1, 1'b1, 32'h67, 1'b1, 1'b0);
    checkOutput("bypass.fifo_dataOut", 64'(data_out[1]), 64'h66);
    checkOutput("bypass.fifo_seqOut", 64'(seq_out[1]), 64'd1);
    step();
    applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bypass.second_dataOut", 64'(data_out[1]), 64'h67);
    checkOutput("bypass.second_seqOut", 64'(seq_out[1]), 64'd2);
    step();
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bypass.empty", 64'(empty[1]), 64'd1);

    // Reset between edges with two words stored.
    applyStimulus(0, 1'b1, 32'h700, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b1, 32'h701, 1'b0, 1'b0); step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("midreset.count_before", 64'(count[0]), 64'd2);
    #1 reset = 1'b0;
    #1;
    checkOutput("midreset.count", 64'(count[0]), 64'd0);
    checkOutput("midreset.readyOut", 64'(ready_out[0]), 64'd0);
    checkOutput("midreset.triggerOut", 64'(trigger_out[0]), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 1'b1, 32'h77, 1'b0, 1'b0);
    step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("postreset.readyOut", 64'(ready_out[0]), 64'd1);
    checkOutput("postreset.dataOut", 64'(data_out[0]), 64'h77);
    checkOutput("postreset.seqOut", 64'(seq_out[0]), 64'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0); step();
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
